// File: rtl/maze_solver_param.sv
// Wall-follower maze solver: walks an external 1-bit maze memory from a start
// cell to any border cell, with selectable hand rule, step limit and enclosure detection.
//
// state | meaning
// IDLE  | waiting for start
// MARK  | write-mark the start cell
// PROBE | pick the next neighbour; out-of-range neighbours count as walls
// CHECK | maze_in valid for the probed cell; move or turn
// DONE  | exit reached, outputs held
// FAIL  | enclosed or step limit reached, outputs held
module maze_solver_param #(
  parameter int ROW_W     = 6,
  parameter int COL_W     = 6,
  parameter int MAX_ROW   = 63,
  parameter int MAX_COL   = 63,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hand,
  input  logic [ROW_W-1:0]  starting_row,
  input  logic [COL_W-1:0]  starting_col,
  input  logic              maze_in,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              maze_oe,
  output logic              maze_we,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [STEP_W-1:0] steps
);

  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(MAX_ROW);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(MAX_COL);
  localparam logic [STEP_W-1:0] STEP_LIM = STEP_W'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE, S_MARK, S_PROBE, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t            state, state_n;
  logic [ROW_W-1:0]  pos_r, pos_r_n, row_n, cand_r;
  logic [COL_W-1:0]  pos_c, pos_c_n, col_n, cand_c;
  logic [1:0]        dir, dir_n, dir_toward, dir_away;
  logic              hand_q, hand_n;
  logic [2:0]        wall_run, wall_run_n;
  logic [STEP_W-1:0] steps_n;
  logic              oe_n, we_n, busy_n, done_n, fail_n;
  logic              cand_ok, at_border;

  // dir: N=0 W=1 S=2 E=3, counterclockwise; a left turn is +1
  always_comb begin
    cand_r  = pos_r;
    cand_c  = pos_c;
    cand_ok = 1'b1;
    case (dir)
      2'd0: if (pos_r == '0)       cand_ok = 1'b0; else cand_r = pos_r - ROW_W'(1);
      2'd1: if (pos_c == '0)       cand_ok = 1'b0; else cand_c = pos_c - COL_W'(1);
      2'd2: if (pos_r == LAST_ROW) cand_ok = 1'b0; else cand_r = pos_r + ROW_W'(1);
      default: if (pos_c == LAST_COL) cand_ok = 1'b0; else cand_c = pos_c + COL_W'(1);
    endcase
  end

  assign dir_toward = hand_q ? dir + 2'd1 : dir - 2'd1;
  assign dir_away   = hand_q ? dir - 2'd1 : dir + 2'd1;
  // in CHECK, row/col carry the probed candidate
  assign at_border  = (row == '0) || (row == LAST_ROW) || (col == '0) || (col == LAST_COL);

  always_comb begin
    state_n    = state;
    pos_r_n    = pos_r;
    pos_c_n    = pos_c;
    row_n      = row;
    col_n      = col;
    dir_n      = dir;
    hand_n     = hand_q;
    wall_run_n = wall_run;
    steps_n    = steps;
    oe_n       = 1'b0;
    we_n       = 1'b0;
    busy_n     = busy;
    done_n     = done;
    fail_n     = fail;
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_n    = S_MARK;
          pos_r_n    = starting_row;
          pos_c_n    = starting_col;
          row_n      = starting_row;
          col_n      = starting_col;
          hand_n     = hand;
          dir_n      = 2'd0;
          steps_n    = '0;
          wall_run_n = '0;
          busy_n     = 1'b1;
          done_n     = 1'b0;
          fail_n     = 1'b0;
          we_n       = 1'b1;
        end
      end
      S_MARK: state_n = S_PROBE;
      S_PROBE: begin
        if ((wall_run == 3'd4) || (steps == STEP_LIM)) begin
          state_n = S_FAIL;
          row_n   = pos_r;
          col_n   = pos_c;
          busy_n  = 1'b0;
          fail_n  = 1'b1;
        end else if (!cand_ok) begin
          dir_n      = dir_away;
          wall_run_n = wall_run + 3'd1;
        end else begin
          state_n = S_CHECK;
          row_n   = cand_r;
          col_n   = cand_c;
          oe_n    = 1'b1;
        end
      end
      S_CHECK: begin
        if (maze_in) begin
          state_n    = S_PROBE;
          row_n      = pos_r;
          col_n      = pos_c;
          dir_n      = dir_away;
          wall_run_n = wall_run + 3'd1;
        end else begin
          pos_r_n    = row;
          pos_c_n    = col;
          we_n       = 1'b1;
          wall_run_n = '0;
          dir_n      = dir_toward;
          if (steps != STEP_LIM) steps_n = steps + STEP_W'(1);
          if (at_border) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = S_PROBE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pos_r    <= '0;
      pos_c    <= '0;
      row      <= '0;
      col      <= '0;
      dir      <= 2'd0;
      hand_q   <= 1'b0;
      wall_run <= '0;
      steps    <= '0;
      maze_oe  <= 1'b0;
      maze_we  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state    <= state_n;
      pos_r    <= pos_r_n;
      pos_c    <= pos_c_n;
      row      <= row_n;
      col      <= col_n;
      dir      <= dir_n;
      hand_q   <= hand_n;
      wall_run <= wall_run_n;
      steps    <= steps_n;
      maze_oe  <= oe_n;
      maze_we  <= we_n;
      busy     <= busy_n;
      done     <= done_n;
      fail     <= fail_n;
    end
  end

endmodule

// File: tb/tb_maze_solver_param.sv
// Directed bench for maze_solver_param: default 64x64 instance, an 8-step-limit
// instance and a 12x20 non-square instance, each backed by a combinational maze array.
module tb_maze_solver_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // default instance
  logic        start0 = 1'b0, hand0 = 1'b0;
  logic [5:0]  sr0 = '0, sc0 = '0, row0, col0;
  logic        maze_in0, oe0, we0, busy0, done0, fail0;
  logic [15:0] steps0;
  logic        mem0 [64][64];
  assign maze_in0 = mem0[row0][col0];

  maze_solver_param dut0 (
    .clk(clk), .rst(rst), .start(start0), .hand(hand0),
    .starting_row(sr0), .starting_col(sc0), .maze_in(maze_in0),
    .row(row0), .col(col0), .maze_oe(oe0), .maze_we(we0),
    .busy(busy0), .done(done0), .fail(fail0), .steps(steps0));

  // step-limit instance
  logic        start1 = 1'b0;
  logic [5:0]  row1, col1;
  logic        maze_in1, oe1, we1, busy1, done1, fail1;
  logic [15:0] steps1;
  logic        mem1 [64][64];
  assign maze_in1 = mem1[row1][col1];

  maze_solver_param #(.MAX_STEPS(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .hand(1'b0),
    .starting_row(6'd10), .starting_col(6'd10), .maze_in(maze_in1),
    .row(row1), .col(col1), .maze_oe(oe1), .maze_we(we1),
    .busy(busy1), .done(done1), .fail(fail1), .steps(steps1));

  // non-square instance
  logic        start2 = 1'b0;
  logic [3:0]  sr2 = '0, row2;
  logic [4:0]  sc2 = '0, col2;
  logic        maze_in2, oe2, we2, busy2, done2, fail2;
  logic [15:0] steps2;
  logic        mem2 [16][32];
  assign maze_in2 = mem2[row2][col2];

  maze_solver_param #(.ROW_W(4), .COL_W(5), .MAX_ROW(11), .MAX_COL(19)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .hand(1'b0),
    .starting_row(sr2), .starting_col(sc2), .maze_in(maze_in2),
    .row(row2), .col(col2), .maze_oe(oe2), .maze_we(we2),
    .busy(busy2), .done(done2), .fail(fail2), .steps(steps2));

  int n_rd, n_wr, both_err, bound_err, timed_out;
  int rd_r [8];
  int rd_c [8];
  int wr_r, wr_c, st_row, st_col;
  logic st_done, st_busy;

  task automatic fill_walls();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) begin
        mem0[i][j] = 1'b1;
        mem1[i][j] = 1'b1;
      end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 32; j++) mem2[i][j] = 1'b1;
  endtask

  task automatic check_timeout(input string name);
    total_cnt++;
    if (timed_out != 0) $display("FAIL %s_timeout: search did not finish within budget", name);
    else pass_cnt++;
  endtask

  task automatic run0(input int r, input int c, input int h, input int budget);
    int cyc;
    @(negedge clk);
    sr0 = 6'(r); sc0 = 6'(c); hand0 = (h != 0); start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n_rd = 0; n_wr = 0; both_err = 0; timed_out = 0; cyc = 0;
    wr_r = -1; wr_c = -1;
    st_done = done0; st_busy = busy0; st_row = int'(row0); st_col = int'(col0);
    forever begin
      if (oe0 && we0) both_err++;
      if (oe0) begin
        if (n_rd < 8) begin rd_r[n_rd] = int'(row0); rd_c[n_rd] = int'(col0); end
        n_rd++;
      end
      if (we0) begin
        if (n_wr == 0) begin wr_r = int'(row0); wr_c = int'(col0); end
        n_wr++;
      end
      if (done0 || fail0) break;
      if (cyc >= budget) begin timed_out = 1; break; end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run2(input int r, input int c, input int budget);
    int cyc;
    @(negedge clk);
    sr2 = 4'(r); sc2 = 5'(c); start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n_rd = 0; bound_err = 0; timed_out = 0; cyc = 0;
    forever begin
      if (row2 > 4'd11 || col2 > 5'd19) bound_err++;
      if (oe2) n_rd++;
      if (done2 || fail2) break;
      if (cyc >= budget) begin timed_out = 1; break; end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({row0, col0, oe0, we0, busy0, done0, fail0, steps0} !== '0)
      $display("FAIL reset_outputs: got row=%0d col=%0d oe=%0b we=%0b busy=%0b done=%0b fail=%0b steps=%0d, want all 0",
               row0, col0, oe0, we0, busy0, done0, fail0, steps0);
    else pass_cnt++;
    total_cnt++;
    if ({busy2, done2, fail2, oe2, we2, steps2} !== '0)
      $display("FAIL reset_nonsquare: got busy=%0b done=%0b fail=%0b steps=%0d, want 0", busy2, done2, fail2, steps2);
    else pass_cnt++;
  endtask

  task automatic test_straight();
    fill_walls();
    for (int r = 0; r <= 5; r++) mem0[r][10] = 1'b0;
    run0(5, 10, 0, 500);
    check_timeout("straight");
    total_cnt++;
    if (wr_r != 5 || wr_c != 10) $display("FAIL straight_mark: got (%0d,%0d) want (5,10)", wr_r, wr_c);
    else pass_cnt++;
    total_cnt++;
    if (rd_r[0] != 4 || rd_c[0] != 10) $display("FAIL straight_first_read: got (%0d,%0d) want (4,10)", rd_r[0], rd_c[0]);
    else pass_cnt++;
    total_cnt++;
    if ({done0, fail0, busy0} !== 3'b100) $display("FAIL straight_flags: got done=%0b fail=%0b busy=%0b want 1 0 0", done0, fail0, busy0);
    else pass_cnt++;
    total_cnt++;
    if (row0 !== 6'd0 || col0 !== 6'd10) $display("FAIL straight_exit: got (%0d,%0d) want (0,10)", row0, col0);
    else pass_cnt++;
    total_cnt++;
    if (steps0 !== 16'd5) $display("FAIL straight_steps: got %0d want 5", steps0);
    else pass_cnt++;
    total_cnt++;
    if (n_wr != 6 || both_err != 0) $display("FAIL straight_writes: got %0d writes, %0d oe/we overlaps, want 6 and 0", n_wr, both_err);
    else pass_cnt++;
  endtask

  task automatic test_enclosed();
    int er [4];
    int ec [4];
    er = '{9, 10, 11, 10};
    ec = '{10, 9, 10, 11};
    fill_walls();
    mem0[10][10] = 1'b0;
    run0(10, 10, 0, 200);
    check_timeout("enclosed");
    total_cnt++;
    if (n_rd != 4) $display("FAIL enclosed_nreads: got %0d want 4", n_rd);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (rd_r[i] != er[i] || rd_c[i] != ec[i])
        $display("FAIL enclosed_read%0d: got (%0d,%0d) want (%0d,%0d)", i, rd_r[i], rd_c[i], er[i], ec[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({fail0, done0, busy0} !== 3'b100 || steps0 !== 16'd0)
      $display("FAIL enclosed_result: got fail=%0b done=%0b busy=%0b steps=%0d want 1 0 0 0", fail0, done0, busy0, steps0);
    else pass_cnt++;
    total_cnt++;
    if (n_wr != 1 || row0 !== 6'd10 || col0 !== 6'd10)
      $display("FAIL enclosed_hold: got writes=%0d pos=(%0d,%0d) want 1 (10,10)", n_wr, row0, col0);
    else pass_cnt++;
  endtask

  task automatic test_hand_restart();
    fill_walls();
    for (int r = 5; r <= 10; r++) mem0[r][30] = 1'b0;
    for (int c = 0; c < 64; c++) mem0[5][c] = 1'b0;
    run0(10, 30, 0, 2000);
    check_timeout("hand_right");
    total_cnt++;
    if (done0 !== 1'b1 || row0 !== 6'd5 || col0 !== 6'd63 || steps0 !== 16'd38)
      $display("FAIL hand_right: got done=%0b (%0d,%0d) steps=%0d want 1 (5,63) 38", done0, row0, col0, steps0);
    else pass_cnt++;
    // restart directly from DONE
    run0(10, 30, 1, 2000);
    total_cnt++;
    if (st_done !== 1'b0 || st_busy !== 1'b1 || st_row != 10 || st_col != 30)
      $display("FAIL restart_latch: got done=%0b busy=%0b (%0d,%0d) want 0 1 (10,30)", st_done, st_busy, st_row, st_col);
    else pass_cnt++;
    check_timeout("hand_left");
    total_cnt++;
    if (done0 !== 1'b1 || row0 !== 6'd5 || col0 !== 6'd0 || steps0 !== 16'd35)
      $display("FAIL hand_left: got done=%0b (%0d,%0d) steps=%0d want 1 (5,0) 35", done0, row0, col0, steps0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n_oe;
    int cyc;
    fill_walls();
    for (int r = 0; r <= 5; r++) mem0[r][10] = 1'b0;
    @(negedge clk);
    sr0 = 6'd5; sc0 = 6'd10; hand0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n_oe = 0; cyc = 0;
    while (n_oe < 3 && cyc < 100) begin
      @(negedge clk);
      if (oe0) n_oe++;
      cyc++;
    end
    total_cnt++;
    if (n_oe != 3 || steps0 !== 16'd1) $display("FAIL midreset_reach: got %0d reads steps=%0d want 3 and 1", n_oe, steps0);
    else pass_cnt++;
    rst = 1'b1; start0 = 1'b1; sr0 = 6'd20; sc0 = 6'd20;
    @(negedge clk);
    rst = 1'b0; start0 = 1'b0;
    total_cnt++;
    if ({row0, col0, oe0, we0, busy0, done0, fail0, steps0} !== '0)
      $display("FAIL midreset_outputs: got row=%0d col=%0d oe=%0b we=%0b busy=%0b steps=%0d want all 0",
               row0, col0, oe0, we0, busy0, steps0);
    else pass_cnt++;
    n_oe = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy0 || oe0 || we0) n_oe++;
    end
    total_cnt++;
    if (n_oe != 0) $display("FAIL midreset_start_ignored: got %0d active cycles want 0", n_oe);
    else pass_cnt++;
  endtask

  task automatic test_step_limit();
    int cyc;
    fill_walls();
    for (int c = 10; c <= 12; c++) begin mem1[10][c] = 1'b0; mem1[12][c] = 1'b0; end
    mem1[11][10] = 1'b0; mem1[11][12] = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0; timed_out = 0;
    while (!(done1 || fail1)) begin
      if (cyc >= 500) begin timed_out = 1; break; end
      @(negedge clk);
      cyc++;
    end
    check_timeout("steplimit");
    total_cnt++;
    if ({fail1, done1, busy1} !== 3'b100 || steps1 !== 16'd8)
      $display("FAIL steplimit: got fail=%0b done=%0b busy=%0b steps=%0d want 1 0 0 8", fail1, done1, busy1, steps1);
    else pass_cnt++;
  endtask

  task automatic test_nonsquare();
    fill_walls();
    for (int r = 5; r <= 11; r++) mem2[r][7] = 1'b0;
    run2(5, 7, 500);
    check_timeout("nonsquare_exit");
    total_cnt++;
    if (done2 !== 1'b1 || row2 !== 4'd11 || col2 !== 5'd7 || steps2 !== 16'd6)
      $display("FAIL nonsquare_exit: got done=%0b (%0d,%0d) steps=%0d want 1 (11,7) 6", done2, row2, col2, steps2);
    else pass_cnt++;
    total_cnt++;
    if (bound_err != 0) $display("FAIL nonsquare_bounds_a: got %0d out-of-range addresses want 0", bound_err);
    else pass_cnt++;
    // corner start: south and east neighbours lie outside the maze
    run2(11, 19, 200);
    check_timeout("nonsquare_corner");
    total_cnt++;
    if (fail2 !== 1'b1 || n_rd != 2 || steps2 !== 16'd0 || row2 !== 4'd11 || col2 !== 5'd19)
      $display("FAIL nonsquare_corner: got fail=%0b reads=%0d steps=%0d (%0d,%0d) want 1 2 0 (11,19)",
               fail2, n_rd, steps2, row2, col2);
    else pass_cnt++;
    total_cnt++;
    if (bound_err != 0) $display("FAIL nonsquare_bounds_b: got %0d out-of-range addresses want 0", bound_err);
    else pass_cnt++;
  endtask

  initial begin
    fill_walls();
    test_reset();
    test_straight();
    test_enclosed();
    test_hand_restart();
    test_reset_mid();
    test_step_limit();
    test_nonsquare();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
